id_ex_reg: RTL and testbench

ID_EX_REG -- requirements
Module: id_ex_reg

---
 rtl/id_ex_reg_if.sv | 56 +++++
 rtl/id_ex_reg.sv | 140 ++++++++++++++
 tb/tb_id_ex_reg.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_reg_if.sv
// Decode-to-execute pipeline register bus.
// It carries the handshake, the decoded fields, the forwarding sources and the
// execute-side outputs.
interface id_ex_reg_if;
  // Handshake with the decode stage and the flush request
  logic        in_valid;
  logic        in_ready;
  logic        flush;

  // Decoded instruction fields
  logic [3:0]  id_funct;
  logic [4:0]  id_dst;
  logic        id_wen;
  logic [4:0]  id_rs_addr;
  logic [4:0]  id_rt_addr;
  logic [31:0] id_rs_val;
  logic [31:0] id_rt_val;
  logic [31:0] id_imm;
  logic [4:0]  id_shamt;
  logic [1:0]  id_src1_sel;
  logic        id_src2_sel;

  // Forwarding sources from the later stages
  logic        mem_wen;
  logic        wb_wen;
  logic [4:0]  mem_dst;
  logic [4:0]  wb_dst;
  logic [31:0] mem_val;
  logic [31:0] wb_val;

  // Handshake with the execute stage and the operands it receives
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  ex_funct;
  logic [31:0] ex_in1;
  logic [31:0] ex_in2;
  logic [31:0] ex_store;
  logic [4:0]  ex_dst;
  logic        ex_wen;

  // Pipeline register side
  modport slave (
    input  in_valid, flush, id_funct, id_dst, id_wen, id_rs_addr, id_rt_addr,
           id_rs_val, id_rt_val, id_imm, id_shamt, id_src1_sel, id_src2_sel,
           mem_wen, wb_wen, mem_dst, wb_dst, mem_val, wb_val, out_ready,
    output in_ready, out_valid, ex_funct, ex_in1, ex_in2, ex_store, ex_dst, ex_wen
  );

  // Decode / execute environment side
  modport master (
    output in_valid, flush, id_funct, id_dst, id_wen, id_rs_addr, id_rt_addr,
           id_rs_val, id_rt_val, id_imm, id_shamt, id_src1_sel, id_src2_sel,
           mem_wen, wb_wen, mem_dst, wb_dst, mem_val, wb_val, out_ready,
    input  in_ready, out_valid, ex_funct, ex_in1, ex_in2, ex_store, ex_dst, ex_wen
  );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with valid/ready handshake, flush, operand forwarding
// and operand source muxing.
// Stored register values are refreshed from the forwarding network while the
// stage is stalled, so a forwarded result is not lost when its producer retires.
module id_ex_reg (
  input  logic         clk,
  input  logic         reset,
  id_ex_reg_if.slave   bus
);

  // Stored instruction
  logic        valid_q,    valid_d;
  logic [3:0]  funct_q,    funct_d;
  logic [4:0]  dst_q,      dst_d;
  logic        wen_q,      wen_d;
  logic [4:0]  rs_addr_q,  rs_addr_d;
  logic [4:0]  rt_addr_q,  rt_addr_d;
  logic [31:0] rs_val_q,   rs_val_d;
  logic [31:0] rt_val_q,   rt_val_d;
  logic [31:0] imm_q,      imm_d;
  logic [4:0]  shamt_q,    shamt_d;
  logic [1:0]  src1_sel_q, src1_sel_d;
  logic        src2_sel_q, src2_sel_d;

  logic        accept;
  logic [31:0] fwd_rs, fwd_rt;
  logic [31:0] cap_rs, cap_rt;

  // Full forwarding: MEM wins over WB; register 0 is never forwarded.
  function automatic logic [31:0] fwd_full(
    input logic [4:0]  addr,  input logic [31:0] stored,
    input logic        m_wen, input logic [4:0]  m_dst, input logic [31:0] m_val,
    input logic        w_wen, input logic [4:0]  w_dst, input logic [31:0] w_val
  );
    if (m_wen && (m_dst == addr) && (addr != 5'd0))      return m_val;
    else if (w_wen && (w_dst == addr) && (addr != 5'd0)) return w_val;
    else                                                 return stored;
  endfunction

  // Forwarding network and the WB-only bypass applied at capture
  always_comb begin
    fwd_rs = fwd_full(rs_addr_q, rs_val_q, bus.mem_wen, bus.mem_dst, bus.mem_val,
                      bus.wb_wen, bus.wb_dst, bus.wb_val);
    fwd_rt = fwd_full(rt_addr_q, rt_val_q, bus.mem_wen, bus.mem_dst, bus.mem_val,
                      bus.wb_wen, bus.wb_dst, bus.wb_val);
    cap_rs = fwd_full(bus.id_rs_addr, bus.id_rs_val, 1'b0, 5'd0, 32'd0,
                      bus.wb_wen, bus.wb_dst, bus.wb_val);
    cap_rt = fwd_full(bus.id_rt_addr, bus.id_rt_val, 1'b0, 5'd0, 32'd0,
                      bus.wb_wen, bus.wb_dst, bus.wb_val);
  end

  assign bus.in_ready = !valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready && !bus.flush;

  // Next-state selection: flush, accept, stall refresh, or drain
  always_comb begin
    valid_d    = valid_q;
    funct_d    = funct_q;
    dst_d      = dst_q;
    wen_d      = wen_q;
    rs_addr_d  = rs_addr_q;
    rt_addr_d  = rt_addr_q;
    rs_val_d   = rs_val_q;
    rt_val_d   = rt_val_q;
    imm_d      = imm_q;
    shamt_d    = shamt_q;
    src1_sel_d = src1_sel_q;
    src2_sel_d = src2_sel_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d    = 1'b1;
      funct_d    = bus.id_funct;
      dst_d      = bus.id_dst;
      wen_d      = bus.id_wen;
      rs_addr_d  = bus.id_rs_addr;
      rt_addr_d  = bus.id_rt_addr;
      rs_val_d   = cap_rs;
      rt_val_d   = cap_rt;
      imm_d      = bus.id_imm;
      shamt_d    = bus.id_shamt;
      src1_sel_d = bus.id_src1_sel;
      src2_sel_d = bus.id_src2_sel;
    end else if (valid_q && !bus.out_ready) begin
      rs_val_d = fwd_rs;
      rt_val_d = fwd_rt;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  // State registers, cleared asynchronously by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= 1'b0;
      funct_q    <= 4'd0;
      dst_q      <= 5'd0;
      wen_q      <= 1'b0;
      rs_addr_q  <= 5'd0;
      rt_addr_q  <= 5'd0;
      rs_val_q   <= 32'd0;
      rt_val_q   <= 32'd0;
      imm_q      <= 32'd0;
      shamt_q    <= 5'd0;
      src1_sel_q <= 2'd0;
      src2_sel_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      funct_q    <= funct_d;
      dst_q      <= dst_d;
      wen_q      <= wen_d;
      rs_addr_q  <= rs_addr_d;
      rt_addr_q  <= rt_addr_d;
      rs_val_q   <= rs_val_d;
      rt_val_q   <= rt_val_d;
      imm_q      <= imm_d;
      shamt_q    <= shamt_d;
      src1_sel_q <= src1_sel_d;
      src2_sel_q <= src2_sel_d;
    end
  end

  // Execute-side operand selection
  always_comb begin
    case (src1_sel_q)
      2'd0:    bus.ex_in1 = fwd_rs;
      2'd1:    bus.ex_in1 = {27'd0, shamt_q};
      2'd2:    bus.ex_in1 = 32'd16;
      default: bus.ex_in1 = 32'd0;
    endcase
    bus.ex_in2   = src2_sel_q ? imm_q : fwd_rt;
    bus.ex_store = fwd_rt;
  end

  assign bus.out_valid = valid_q;
  assign bus.ex_funct  = funct_q;
  assign bus.ex_dst    = dst_q;
  assign bus.ex_wen    = wen_q && valid_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: reset, capture, back-to-back flow, forwarding
// priority, stall refresh, flush, register-0 handling and reset mid-stall.
module tb_id_ex_reg;
  logic clk;
  logic reset;
  int   errors;
  int   checks;

  id_ex_reg_if bus ();

  id_ex_reg dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.in_valid    = 1'b0;
    bus.flush       = 1'b0;
    bus.out_ready   = 1'b0;
    bus.id_funct    = 4'd0;
    bus.id_dst      = 5'd0;
    bus.id_wen      = 1'b0;
    bus.id_rs_addr  = 5'd0;
    bus.id_rt_addr  = 5'd0;
    bus.id_rs_val   = 32'd0;
    bus.id_rt_val   = 32'd0;
    bus.id_imm      = 32'd0;
    bus.id_shamt    = 5'd0;
    bus.id_src1_sel = 2'd0;
    bus.id_src2_sel = 1'b0;
    bus.mem_wen     = 1'b0;
    bus.wb_wen      = 1'b0;
    bus.mem_dst     = 5'd0;
    bus.wb_dst      = 5'd0;
    bus.mem_val     = 32'd0;
    bus.wb_val      = 32'd0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("rst_ex_wen",    {31'd0, bus.ex_wen},    32'd0);
    chk("rst_ex_funct",  {28'd0, bus.ex_funct},  32'd0);
    chk("rst_ex_dst",    {27'd0, bus.ex_dst},    32'd0);
    chk("rst_ex_in1",    bus.ex_in1,             32'd0);
    chk("rst_ex_in2",    bus.ex_in2,             32'd0);
    chk("rst_ex_store",  bus.ex_store,           32'd0);
    reset = 1'b0;
    tick();

    // Basic capture: rs=5 (7), imm=3 via src2_sel=1
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    bus.id_funct = 4'b0000; bus.id_dst = 5'd3; bus.id_wen = 1'b1;
    bus.id_rs_addr = 5'd5; bus.id_rs_val = 32'd7;
    bus.id_rt_addr = 5'd6; bus.id_rt_val = 32'h55;
    bus.id_imm = 32'd3; bus.id_src1_sel = 2'd0; bus.id_src2_sel = 1'b1;
    tick();
    chk("cap_out_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("cap_ex_in1",    bus.ex_in1,             32'd7);
    chk("cap_ex_in2",    bus.ex_in2,             32'd3);
    chk("cap_ex_store",  bus.ex_store,           32'h55);
    chk("cap_ex_wen",    {31'd0, bus.ex_wen},    32'd1);
    chk("cap_ex_dst",    {27'd0, bus.ex_dst},    32'd3);

    // Back-to-back replace: constant 16 and immediate
    bus.id_funct = 4'b0110; bus.id_dst = 5'd9; bus.id_wen = 1'b0;
    bus.id_src1_sel = 2'd2; bus.id_imm = 32'h0000ABCD; bus.id_src2_sel = 1'b1;
    #1;
    chk("b2b_in_ready",  {31'd0, bus.in_ready},  32'd1);
    tick();
    chk("b2b_out_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("b2b_ex_in1",    bus.ex_in1,             32'd16);
    chk("b2b_ex_in2",    bus.ex_in2,             32'h0000ABCD);
    chk("b2b_ex_funct",  {28'd0, bus.ex_funct},  32'd6);
    chk("b2b_ex_wen",    {31'd0, bus.ex_wen},    32'd0);

    // Drain with no new instruction
    bus.in_valid = 1'b0;
    tick();
    chk("drain_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("drain_ex_wen",    {31'd0, bus.ex_wen},    32'd0);

    // Capture rs=8 (0x11), rt=12 (0x99) then stall
    bus.in_valid = 1'b1; bus.id_wen = 1'b1; bus.id_dst = 5'd2; bus.id_funct = 4'd1;
    bus.id_rs_addr = 5'd8; bus.id_rs_val = 32'h11;
    bus.id_rt_addr = 5'd12; bus.id_rt_val = 32'h99;
    bus.id_src1_sel = 2'd0; bus.id_src2_sel = 1'b0;
    tick();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.mem_wen = 1'b1; bus.mem_dst = 5'd8; bus.mem_val = 32'hAA;
    bus.wb_wen  = 1'b1; bus.wb_dst  = 5'd8; bus.wb_val  = 32'hBB;
    #1;
    chk("prio_mem_over_wb", bus.ex_in1, 32'hAA);
    chk("stall_in_ready",   {31'd0, bus.in_ready}, 32'd0);
    bus.mem_wen = 1'b0;
    #1;
    chk("wb_only_fwd", bus.ex_in1, 32'hBB);
    bus.wb_wen = 1'b0;
    #1;
    chk("no_fwd_stored", bus.ex_in1, 32'h11);

    // Stall for three cycles; WB supplies rt only in the first
    bus.wb_wen = 1'b1; bus.wb_dst = 5'd12; bus.wb_val = 32'h1234;
    #1;
    chk("stall_c1_in2",      bus.ex_in2, 32'h1234);
    chk("stall_c1_in_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    bus.wb_wen = 1'b0; bus.wb_val = 32'h0;
    #1;
    chk("stall_c2_in2",      bus.ex_in2, 32'h1234);
    chk("stall_c2_store",    bus.ex_store, 32'h1234);
    chk("stall_c2_in_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    chk("stall_c3_in2",      bus.ex_in2, 32'h1234);
    chk("stall_c3_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("stall_c3_valid",    {31'd0, bus.out_valid}, 32'd1);

    // Flush while holding, with an incoming instruction
    bus.flush = 1'b1; bus.in_valid = 1'b1;
    bus.id_dst = 5'd20; bus.id_wen = 1'b1; bus.id_src1_sel = 2'd2;
    #1;
    chk("flush_in_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    #1;
    chk("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("flush_ex_wen",    {31'd0, bus.ex_wen},    32'd0);
    tick();
    chk("flush_not_presented", {31'd0, bus.out_valid}, 32'd0);

    // Capture-time WB bypass on rt, then register 0 is never forwarded
    bus.in_valid = 1'b1; bus.id_wen = 1'b1; bus.id_dst = 5'd7;
    bus.id_rs_addr = 5'd0; bus.id_rs_val = 32'd0;
    bus.id_rt_addr = 5'd4; bus.id_rt_val = 32'h1;
    bus.id_src1_sel = 2'd0; bus.id_src2_sel = 1'b0;
    bus.wb_wen = 1'b1; bus.wb_dst = 5'd4; bus.wb_val = 32'hCAFE;
    tick();
    bus.in_valid = 1'b0; bus.wb_wen = 1'b0; bus.wb_val = 32'h0;
    #1;
    chk("cap_wb_bypass", bus.ex_in2, 32'hCAFE);
    bus.mem_wen = 1'b1; bus.mem_dst = 5'd0; bus.mem_val = 32'hFFFFFFFF;
    bus.wb_wen = 1'b1; bus.wb_dst = 5'd0; bus.wb_val = 32'hFFFFFFFF;
    #1;
    chk("r0_no_fwd", bus.ex_in1, 32'd0);
    bus.mem_wen = 1'b0; bus.wb_wen = 1'b0;
    tick();

    // Asynchronous reset while stalled drops the entry
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_mid_in2",   bus.ex_in2, 32'd0);
    chk("rst_mid_wen",   {31'd0, bus.ex_wen}, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // First accept after reset: shamt source
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    bus.id_src1_sel = 2'd1; bus.id_shamt = 5'd17; bus.id_dst = 5'd1; bus.id_wen = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("post_rst_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("shamt_in1",      bus.ex_in1, 32'd17);
    tick();
    chk("post_rst_drain", {31'd0, bus.out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety bound so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
